// File: rtl/stream_cmul_n_if.sv
// Stream bundle for stream_cmul_n: NUM_INPUTS input lanes plus one output lane.
interface stream_cmul_n_if #(
    parameter int unsigned NUM_INPUTS = 2,
    parameter int unsigned WIDTH      = 16
);
    logic [NUM_INPUTS*2*WIDTH-1:0] i_tdata;
    logic [NUM_INPUTS-1:0]         i_tlast;
    logic [NUM_INPUTS-1:0]         i_tvalid;
    logic [NUM_INPUTS-1:0]         i_tready;
    logic [2*WIDTH-1:0]            o_tdata;
    logic                          o_tlast;
    logic                          o_tvalid;
    logic                          o_tready;

    // Producer of input beats and consumer of products
    modport master (
        output i_tdata, i_tlast, i_tvalid, o_tready,
        input  i_tready, o_tdata, o_tlast, o_tvalid
    );

    // The multiplier itself
    modport slave (
        input  i_tdata, i_tlast, i_tvalid, o_tready,
        output i_tready, o_tdata, o_tlast, o_tvalid
    );
endinterface

// File: rtl/stream_cmul_n.sv
// Streaming N-way complex multiplier: joins NUM_INPUTS lockstep streams and
// emits ((x0*x1)*x2)*x3 through a cascade of two-cycle multiply stages.
module stream_cmul_n #(
    parameter int unsigned NUM_INPUTS = 2,
    parameter int unsigned WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic [NUM_INPUTS-1:0] conj_mask,
    stream_cmul_n_if.slave        bus,
    output logic                  tlast_err,
    output logic [15:0]           err_count
);
    localparam int unsigned Stages = NUM_INPUTS - 1;
    localparam int unsigned Depth  = 2 * Stages;
    localparam int unsigned ProdW  = 2 * WIDTH;
    localparam int unsigned SumW   = 2 * WIDTH + 1;

    localparam logic signed [WIDTH-1:0] MaxVal = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [SumW-1:0]  RndVal = {{(WIDTH+2){1'b0}}, 1'b1, {(WIDTH-2){1'b0}}};
    localparam logic signed [SumW-1:0]  SatHi  = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [SumW-1:0]  SatLo  = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

    // Round half-up, rescale by 2^(WIDTH-1), clamp to the signed WIDTH range
    function automatic logic signed [WIDTH-1:0] rnd_sat(input logic signed [SumW-1:0] v);
        logic signed [SumW-1:0] t;
        t = (v + RndVal) >>> (WIDTH - 1);
        if (t > SatHi) begin
            rnd_sat = MaxVal;
        end else if (t < SatLo) begin
            rnd_sat = MinVal;
        end else begin
            rnd_sat = t[WIDTH-1:0];
        end
    endfunction

    logic                    w_en;
    logic                    w_accept;
    logic                    w_last;
    logic                    w_mismatch;
    logic signed [WIDTH-1:0] w_xi [NUM_INPUTS];
    logic signed [WIDTH-1:0] w_rq [NUM_INPUTS];
    logic signed [WIDTH-1:0] w_xq [NUM_INPUTS];
    logic signed [WIDTH-1:0] w_res_i [Stages];
    logic signed [WIDTH-1:0] w_res_q [Stages];

    logic [Depth-1:0]        r_vld;
    logic [Depth-1:0]        r_last;
    logic                    r_err;
    logic [15:0]             r_cnt;

    // The whole pipeline moves as one; a stalled output freezes every stage
    assign w_en         = ~bus.o_tvalid | bus.o_tready;
    assign w_accept     = reset_n & ~clear & w_en & (&bus.i_tvalid);
    assign bus.i_tready = {NUM_INPUTS{w_accept}};
    assign w_last       = |bus.i_tlast;
    assign w_mismatch   = w_accept & w_last & ~(&bus.i_tlast);

    // Unpack each lane; conjugation negates Q, folding -2^(WIDTH-1) onto the max
    for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_lane
        assign w_xi[k] = bus.i_tdata[k*2*WIDTH+WIDTH +: WIDTH];
        assign w_rq[k] = bus.i_tdata[k*2*WIDTH +: WIDTH];
        assign w_xq[k] = !conj_mask[k] ? w_rq[k] :
                         (w_rq[k] == MinVal) ? MaxVal : -w_rq[k];
    end

    for (genvar s = 0; s < Stages; s++) begin : g_stage
        logic signed [WIDTH-1:0] w_ai, w_aq, w_bi, w_bq;
        logic signed [ProdW-1:0] r_pp_rr, r_pp_ii, r_pp_ri, r_pp_ir;
        logic signed [SumW-1:0]  w_re, w_im;
        logic signed [WIDTH-1:0] r_yi, r_yq;

        if (s == 0) begin : g_first
            assign w_ai = w_xi[0];
            assign w_aq = w_xq[0];
            assign w_bi = w_xi[1];
            assign w_bq = w_xq[1];
        end else begin : g_next
            logic signed [WIDTH-1:0] r_di [2*s];
            logic signed [WIDTH-1:0] r_dq [2*s];

            // Delay later operands so they meet the running product of the same beat
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < 2*s; i++) begin
                        r_di[i] <= '0;
                        r_dq[i] <= '0;
                    end
                end else if (w_en) begin
                    r_di[0] <= w_xi[s+1];
                    r_dq[0] <= w_xq[s+1];
                    for (int i = 1; i < 2*s; i++) begin
                        r_di[i] <= r_di[i-1];
                        r_dq[i] <= r_dq[i-1];
                    end
                end
            end

            assign w_ai = w_res_i[s-1];
            assign w_aq = w_res_q[s-1];
            assign w_bi = r_di[2*s-1];
            assign w_bq = r_dq[2*s-1];
        end

        assign w_re = SumW'(r_pp_rr) - SumW'(r_pp_ii);
        assign w_im = SumW'(r_pp_ri) + SumW'(r_pp_ir);

        // Cycle 1 registers the partial products, cycle 2 the rounded sums
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_pp_rr <= '0;
                r_pp_ii <= '0;
                r_pp_ri <= '0;
                r_pp_ir <= '0;
                r_yi    <= '0;
                r_yq    <= '0;
            end else if (w_en) begin
                r_pp_rr <= ProdW'(w_ai) * ProdW'(w_bi);
                r_pp_ii <= ProdW'(w_aq) * ProdW'(w_bq);
                r_pp_ri <= ProdW'(w_ai) * ProdW'(w_bq);
                r_pp_ir <= ProdW'(w_aq) * ProdW'(w_bi);
                r_yi    <= rnd_sat(w_re);
                r_yq    <= rnd_sat(w_im);
            end
        end

        assign w_res_i[s] = r_yi;
        assign w_res_q[s] = r_yq;
    end

    // Valid and last ride alongside the data; clear only empties the valid chain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld  <= '0;
            r_last <= '0;
        end else if (clear) begin
            r_vld  <= '0;
        end else if (w_en) begin
            r_vld  <= {r_vld[Depth-2:0], w_accept};
            r_last <= {r_last[Depth-2:0], w_last};
        end
    end

    // Sticky mismatch flag and saturating mismatch counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
            r_cnt <= '0;
        end else if (clear) begin
            r_err <= 1'b0;
            r_cnt <= '0;
        end else if (w_mismatch) begin
            r_err <= 1'b1;
            if (r_cnt != 16'hFFFF) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign bus.o_tvalid = r_vld[Depth-1];
    assign bus.o_tlast  = r_last[Depth-1];
    assign bus.o_tdata  = {w_res_i[Stages-1], w_res_q[Stages-1]};
    assign tlast_err    = r_err;
    assign err_count    = r_cnt;
endmodule
